// File: rtl/stopwatch_up.sv
// Count-up minute/second stopwatch. Digits are held as BCD and shown in the same
// packed min_sec format as the countdown timer. The stopwatch has start/stop,
// clear and lap-freeze controls, and it saturates at MAX_MIN:59.
module stopwatch_up #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] min_sec,
    output logic        running,
    output logic        lap_active,
    output logic        full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FULL  = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] min_tens;
        logic [3:0] min_units;
        logic [2:0] sec_tens;
        logic [3:0] sec_units;
    } bcd_t;

    localparam logic [2:0] MAX_TENS  = 3'(MAX_MIN / 10);
    localparam logic [3:0] MAX_UNITS = 4'(MAX_MIN % 10);
    localparam bcd_t       TOP_COUNT = {MAX_TENS, MAX_UNITS, 3'd5, 4'd9};

    function automatic logic [15:0] to_display(input bcd_t d);
        return {1'b0, d.min_tens, d.min_units, 1'b0, d.sec_tens, d.sec_units};
    endfunction

    state_t state, nxt_state;
    bcd_t   count, nxt_count, inc_count;
    bcd_t   snap, nxt_snap;
    logic   nxt_lap;
    logic   hits_top;
    logic   counting;

    // Ripple a one-second increment through the four BCD digits.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a default
        // first, so no latch is inferred; registers below use non-blocking '<=' only.
        inc_count = count;
        if (count.sec_units != 4'd9) begin
            inc_count.sec_units = count.sec_units + 4'd1;
        end else begin
            inc_count.sec_units = 4'd0;
            if (count.sec_tens != 3'd5) begin
                inc_count.sec_tens = count.sec_tens + 3'd1;
            end else begin
                inc_count.sec_tens = 3'd0;
                if (count.min_units != 4'd9) begin
                    inc_count.min_units = count.min_units + 4'd1;
                end else begin
                    inc_count.min_units = 4'd0;
                    inc_count.min_tens  = count.min_tens + 3'd1;
                end
            end
        end
        hits_top = (inc_count == TOP_COUNT);
    end

    assign counting = (state == RUN) && tick;

    // Next-state logic. The priority is clear, then start_stop, then lap.
    always_comb begin
        nxt_state = state;
        nxt_count = count;
        nxt_snap  = snap;
        nxt_lap   = lap_active;

        if (clear) begin
            nxt_state = IDLE;
            nxt_count = '0;
            nxt_lap   = 1'b0;
        end else begin
            if (counting) begin
                nxt_count = inc_count;
            end

            if (start_stop) begin
                case (state)
                    IDLE:    nxt_state = RUN;
                    RUN:     nxt_state = PAUSE;
                    PAUSE:   nxt_state = RUN;
                    default: nxt_state = state;
                endcase
            end else if (lap) begin
                if (lap_active) begin
                    nxt_lap = 1'b0;
                end else if (state == RUN || state == PAUSE) begin
                    nxt_snap = count;
                    nxt_lap  = 1'b1;
                end
            end

            // Landing on the top count saturates even when a pause arrives with the tick.
            if (counting && hits_top) begin
                nxt_state = FULL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            snap       <= '0;
            lap_active <= 1'b0;
            min_sec    <= 16'h0000;
            running    <= 1'b0;
            full       <= 1'b0;
        end else begin
            state      <= nxt_state;
            count      <= nxt_count;
            snap       <= nxt_snap;
            lap_active <= nxt_lap;
            min_sec    <= to_display(nxt_lap ? nxt_snap : nxt_count);
            running    <= (nxt_state == RUN);
            full       <= (nxt_state == FULL);
        end
    end

    a_legal_bcd : assert property (@(posedge clk) disable iff (!rst_n)
        count.sec_units <= 4'd9 && count.sec_tens <= 3'd5 &&
        count.min_units <= 4'd9 && count.min_tens <= 3'd5);

    a_full_at_top : assert property (@(posedge clk) disable iff (!rst_n)
        (state == FULL) |-> (count == TOP_COUNT));

endmodule

// File: tb/tb_stopwatch_up.sv
// Scoreboard bench for stopwatch_up. Two instances (MAX_MIN=59 and MAX_MIN=2) share
// stimulus; a seconds-based reference model predicts every cycle's registered outputs.
module tb_stopwatch_up;

    logic        clk = 1'b0;
    logic        rst_n, tick, start_stop, clear, lap;
    logic [15:0] min_sec_a, min_sec_b;
    logic        running_a, lap_active_a, full_a;
    logic        running_b, lap_active_b, full_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stopwatch_up #(.MAX_MIN(59)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .min_sec(min_sec_a), .running(running_a),
        .lap_active(lap_active_a), .full(full_a)
    );

    stopwatch_up #(.MAX_MIN(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .min_sec(min_sec_b), .running(running_b),
        .lap_active(lap_active_b), .full(full_b)
    );

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FULL = 3;

    typedef struct packed {
        int secs;
        int snap;
        int top;
        int mode;
        bit lap_act;
    } model_t;

    typedef struct packed {
        logic [15:0] min_sec;
        logic        running;
        logic        lap_active;
        logic        full;
    } out_t;

    model_t m_a, m_b;
    out_t   exp_q_a[$];
    out_t   exp_q_b[$];

    function automatic logic [15:0] enc(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {1'b0, 3'(mm / 10), 4'(mm % 10), 1'b0, 3'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic model_t step(input model_t m, input bit rn, tk, ss, cl, lp);
        model_t n;
        n = m;
        if (!rn) begin
            n.secs = 0; n.snap = 0; n.mode = M_IDLE; n.lap_act = 1'b0;
            return n;
        end
        if (cl) begin
            n.secs = 0; n.mode = M_IDLE; n.lap_act = 1'b0;
            return n;
        end
        if (m.mode == M_RUN && tk) n.secs = m.secs + 1;
        if (ss) begin
            if (m.mode == M_IDLE || m.mode == M_PAUSE) n.mode = M_RUN;
            else if (m.mode == M_RUN) n.mode = M_PAUSE;
        end else if (lp) begin
            if (m.lap_act) n.lap_act = 1'b0;
            else if (m.mode == M_RUN || m.mode == M_PAUSE) begin
                n.snap = m.secs;
                n.lap_act = 1'b1;
            end
        end
        if (m.mode == M_RUN && tk && n.secs == m.top) n.mode = M_FULL;
        return n;
    endfunction

    function automatic out_t predict(input model_t m);
        out_t o;
        o.min_sec    = enc(m.lap_act ? m.snap : m.secs);
        o.running    = (m.mode == M_RUN);
        o.lap_active = m.lap_act;
        o.full       = (m.mode == M_FULL);
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_a(input string name, input logic [15:0] ms, input bit r, la, f);
        check(name, {13'b0, min_sec_a, running_a, lap_active_a, full_a}, {13'b0, ms, r, la, f});
    endtask

    task automatic check_b(input string name, input logic [15:0] ms, input bit r, la, f);
        check(name, {13'b0, min_sec_b, running_b, lap_active_b, full_b}, {13'b0, ms, r, la, f});
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, and return #1 after the edge.
    task automatic cycle(input bit rn, tk, ss, cl, lp);
        rst_n = rn; tick = tk; start_stop = ss; clear = cl; lap = lp;
        m_a = step(m_a, rn, tk, ss, cl, lp);
        m_b = step(m_b, rn, tk, ss, cl, lp);
        exp_q_a.push_back(predict(m_a));
        exp_q_b.push_back(predict(m_b));
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUTs present registered outputs, so one entry pops per edge.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (exp_q_a.size() > 0) begin
                e = exp_q_a.pop_front();
                check("sb_a", {13'b0, min_sec_a, running_a, lap_active_a, full_a}, {13'b0, e});
            end
            if (exp_q_b.size() > 0) begin
                e = exp_q_b.pop_front();
                check("sb_b", {13'b0, min_sec_b, running_b, lap_active_b, full_b}, {13'b0, e});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_a = '0; m_a.top = 59 * 60 + 59;
        m_b = '0; m_b.top = 2 * 60 + 59;

        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check_a("reset_a", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_b("reset_b", 16'h0000, 1'b0, 1'b0, 1'b0);

        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_a("start_tick_ignored", 16'h0000, 1'b1, 1'b0, 1'b0);
        ticks(61);
        check_a("count_61", 16'h0101, 1'b1, 1'b0, 1'b0);

        ticks(118);
        check_b("sat_179", 16'h0259, 1'b0, 1'b0, 1'b1);
        ticks(5);
        check_b("sat_hold", 16'h0259, 1'b0, 1'b0, 1'b1);
        check_a("count_184", 16'h0304, 1'b1, 1'b0, 1'b0);

        ticks(415);
        check_a("count_0959", 16'h0959, 1'b1, 1'b0, 1'b0);
        ticks(1);
        check_a("carry_1000", 16'h1000, 1'b1, 1'b0, 1'b0);

        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_a("clear_a", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_b("clear_full_b", 16'h0000, 1'b0, 1'b0, 1'b0);

        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        check_a("run_0010", 16'h0010, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_a("lap_on", 16'h0010, 1'b1, 1'b1, 1'b0);
        ticks(5);
        check_a("lap_frozen", 16'h0010, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_a("lap_off", 16'h0015, 1'b1, 1'b0, 1'b0);

        ticks(5);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_a("pause_tick_counted", 16'h0021, 1'b0, 1'b0, 1'b0);
        ticks(3);
        check_a("paused_hold", 16'h0021, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        check_a("resume", 16'h0022, 1'b1, 1'b0, 1'b0);

        ticks(8);
        check_a("run_0030", 16'h0030, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_a("clear_ss_lap", 16'h0000, 1'b0, 1'b0, 1'b0);

        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_a("lap_before_rst", 16'h0003, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check_a("rst_midrun", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_b("rst_midrun_b", 16'h0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        #1;
        check("sb_drained", exp_q_a.size() + exp_q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_up.md
Name: stopwatch_up

Overview:
- Count-up companion to the countdown minute/second timer: elapsed time counts upward from 00:00 and is shown in the same packed decimal min_sec format as the timer.
- Counters are held directly as BCD digits, so no binary-to-decimal conversion stage is needed.
- Provides start/stop, clear and lap-freeze control, and saturates at the top count.
- Sits beside the countdown timer and drives the same display mux.

Parameters:
- MAX_MIN, 59: highest minute value (decimal, 1..59). Count saturates at MAX_MIN:59.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- tick  in  1  one-cycle 1 Hz enable strobe; each high cycle counts as one second
- start_stop  in  1  one-cycle pulse; toggles between running and paused
- clear  in  1  one-cycle pulse; returns the count to 00:00 and stops
- lap  in  1  one-cycle pulse; toggles the display freeze
- min_sec  out  16  display value:
  - [15]=0
  - [14:12] minute tens
  - [11:8] minute units
  - [7]=0
  - [6:4] second tens
  - [3:0] second units
- running  out  1  high in state RUN
- lap_active  out  1  display frozen at the lap snapshot
- full  out  1  count saturated at MAX_MIN:59

Behaviour:
- Reset: rst_n low at a clk edge sets:
  - all digits to 0
  - the lap snapshot to 0
  - the state to IDLE
  - min_sec=16'h0000, running=0, lap_active=0, full=0
- Reset overrides every other input, including a reset asserted mid-count or while the display is frozen.
- States:
  - IDLE: count = 00:00, not counting.
  - RUN: counting.
  - PAUSE: holding a nonzero count.
  - FULL: saturated, not counting.
- Transitions (evaluated once per clk edge, priority clear > start_stop > lap):
  - clear, from any state: go to IDLE, digits=0, lap_active=0.
  - start_stop: IDLE→RUN, RUN→PAUSE, PAUSE→RUN, FULL→FULL (ignored).
  - RUN→FULL: when an increment reaches MAX_MIN:59.
- Counting:
  - Occurs only when the current (pre-edge) state is RUN and tick=1 in that cycle.
  - A tick arriving in the same cycle as the start_stop that leaves IDLE or PAUSE is not counted.
  - A tick arriving in the same cycle as the start_stop that enters PAUSE is counted.
- Increment order, 1 per counted tick:
  - Second units 9→0 carries into second tens.
  - Second tens 5→0 (at x:59) carries into minute units.
  - Minute units 9→0 carries into minute tens.
- Saturation:
  - The increment that lands on MAX_MIN:59 enters FULL in the same edge; full=1 from that edge on.
  - Further ticks leave the value unchanged. There is no wrap to 00:00.
  - Only clear or reset leaves FULL.
- Lap:
  - A lap pulse while lap_active=0 and state is RUN or PAUSE: snapshot the current pre-increment count and set lap_active=1.
  - A lap pulse while lap_active=1, in any state: lap_active=0.
  - A lap pulse in IDLE or FULL with lap_active=0 is ignored.
  - Counting continues underneath the freeze.
  - lap in the same cycle as clear or start_stop is ignored; the higher-priority action alone takes effect.
- Output:
  - min_sec = lap snapshot when lap_active=1, otherwise the live digits.
  - Registered: it reflects the state after the edge, so there is 1 cycle of latency from a tick to the new value.
- Digits are always legal BCD: second tens 0..5, second units 0..9, minute tens 0..5.

Test Plan:
- Reset, then start_stop, then 61 ticks → min_sec=16'h0101, running=1, full=0; a tick issued in the start_stop cycle must not be counted.
- Count to 09:59, then one more tick → min_sec=16'h1000 (carry through all four digits).
- MAX_MIN=2: run 179 ticks → min_sec=16'h0259, full=1, running=0; then 5 more ticks → still 16'h0259; then clear → 16'h0000, full=0, state IDLE.
- RUN at 00:10, lap, then 5 ticks → min_sec=16'h0010 and lap_active=1; lap again → min_sec=16'h0015 and lap_active=0.
- RUN at 00:20, start_stop with tick in the same cycle → 00:21 and running=0; 3 more ticks → 00:21; start_stop, then 1 tick → 00:22.
- Simultaneous events:
  - clear+start_stop+lap in one cycle at 00:30 → IDLE, 16'h0000, lap_active=0.
  - rst_n low while RUN with lap_active=1 → all outputs 0 on the next edge.
